// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// LSU_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into errors.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WRITE,
        RESP
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] LANE_0 = 2'b00;

    function automatic logic f3_legal(
        input logic       write,
        input logic [2:0] f3
    );
        if (write)
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        else
            return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW)
                || (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    function automatic logic misaligned(
        input logic [2:0] f3,
        input logic [1:0] lane
    );
        return ((f3[1:0] == SZ_HALF) && lane[0])
            || ((f3[1:0] == SZ_WORD) && (lane != LANE_0));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extract/extend for loads and lane merge for sub-word stores.
// Misaligned halfword/word lanes are truncated to natural alignment.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [4:0]  sh;
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;

    assign sh      = {lane, 3'b000};
    assign shifted = word >> sh;
    assign b       = shifted[7:0];
    assign h       = lane[1] ? word[31:16] : word[15:0];

    always_comb begin
        load_data = '0;
        case (funct3)
            F3_LB:   load_data = {{24{b[7]}}, b};
            F3_LH:   load_data = {{16{h[15]}}, h};
            F3_LW:   load_data = word;
            F3_LBU:  load_data = {24'h0, b};
            F3_LHU:  load_data = {16'h0, h};
            default: load_data = '0;
        endcase
    end

    always_comb begin
        store_data = word;
        case (funct3[1:0])
            SZ_BYTE: store_data = (word & ~(32'hFF << sh))
                                | ({24'h0, wdata[7:0]} << sh);
            SZ_HALF: store_data = lane[1]
                                ? {wdata[15:0], word[15:0]}
                                : {word[31:16], wdata[15:0]};
            SZ_WORD: store_data = wdata;
            default: store_data = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multicycle byte/half/word load-store initiator with RMW sub-word stores.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_error,
    output logic              mem_writeEn,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    state_t            state;
    logic              write_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] store_data;
    logic              bad;

`ifdef LSU_MISALIGN_TRAP_EN
    assign bad = !f3_legal(write_q, funct3_q)
              || misaligned(funct3_q, addr_q[1:0]);
`else
    assign bad = !f3_legal(write_q, funct3_q);
`endif

    lsu_align u_align (
        .word       (mem_read_data),
        .wdata      (wdata_q),
        .lane       (addr_q[1:0]),
        .funct3     (funct3_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    // All outputs are registered and set on the transition into each state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            write_q        <= 1'b0;
            funct3_q       <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            resp_error     <= 1'b0;
            mem_writeEn    <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q     <= req_write;
                        funct3_q    <= req_funct3;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        req_ready   <= 1'b0;
                        mem_address <= {req_addr[ADDR_W-1:2], 2'b00};
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (bad) begin
                        mem_address <= '0;
                        resp_valid  <= 1'b1;
                        resp_error  <= 1'b1;
                        state       <= RESP;
                    end else if (!write_q) begin
                        mem_address <= '0;
                        resp_valid  <= 1'b1;
                        resp_rdata  <= load_data;
                        state       <= RESP;
                    end else begin
                        mem_writeEn    <= 1'b1;
                        mem_write_data <= store_data;
                        state          <= WRITE;
                    end
                end
                WRITE: begin
                    mem_writeEn    <= 1'b0;
                    mem_address    <= '0;
                    mem_write_data <= '0;
                    resp_valid     <= 1'b1;
                    state          <= RESP;
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    resp_rdata <= '0;
                    resp_error <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench for load_store_unit with a word memory model.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_writeEn;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:511];

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
    } exp_t;

    exp_t sb_q[$];
    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    assign mem_read_data = mem[mem_address[10:2]];

    always @(posedge clock)
        if (mem_writeEn)
            mem[mem_address[10:2]] <= mem_write_data;

    load_store_unit dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_error     (resp_error),
        .mem_writeEn    (mem_writeEn),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one request at a negedge, held until accepted (bounded).
    task automatic drive(input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        int n;
        n = 0;
        @(negedge clock);
        while (!req_ready && n < 10) begin
            @(negedge clock);
            n++;
        end
        check("ready_wait", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic do_req(input string tag,
                          input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rdata,
                          input logic exp_err,
                          input int exp_lat,
                          input logic [31:0] exp_wd);
        int   lat;
        int   we_cnt;
        int   we_cyc;
        logic [31:0] we_data;
        logic got;
        exp_t e;
        sb_q.push_back('{rdata: exp_rdata, error: exp_err});
        drive(w, f3, a, d);
        lat = 0; we_cnt = 0; we_cyc = 0; we_data = 0; got = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            if (c == 1)
                check({tag, "_addr"}, mem_address, a & 32'hFFFF_FFFC);
            if (mem_writeEn) begin
                we_cnt++;
                we_cyc  = c;
                we_data = mem_write_data;
            end
            if (resp_valid) begin
                got = 1;
                lat = c;
                break;
            end
        end
        check({tag, "_resp_seen"}, {31'b0, got}, 32'd1);
        e = sb_q.pop_front();
        if (got) begin
            check({tag, "_latency"}, lat, exp_lat);
            check({tag, "_rdata"}, resp_rdata, e.rdata);
            check({tag, "_error"}, {31'b0, resp_error}, {31'b0, e.error});
        end
        if (w && !exp_err) begin
            check({tag, "_we_count"}, we_cnt, 1);
            check({tag, "_we_cycle"}, we_cyc, 2);
            check({tag, "_we_data"}, we_data, exp_wd);
        end else begin
            check({tag, "_no_we"}, we_cnt, 0);
        end
        @(negedge clock);
        check({tag, "_pulse_end"}, {31'b0, resp_valid}, 32'd0);
        check({tag, "_ready_back"}, {31'b0, req_ready}, 32'd1);
    endtask

    initial begin : main
        int pulses;
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        mem[32'h100 >> 2] = 32'h80FF7F01;
        mem[32'h104 >> 2] = 32'h55667788;
        mem[32'h200 >> 2] = 32'h11223344;
        mem[32'h300 >> 2] = 32'h00000000;
        mem[32'h400 >> 2] = 32'hCAFEF00D;

        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_error", {31'b0, resp_error}, 32'd0);
        check("rst_we", {31'b0, mem_writeEn}, 32'd0);
        check("rst_addr", mem_address, 32'd0);
        check("rst_wdata", mem_write_data, 32'd0);

        do_req("lb_102", 0, 3'b000, 32'h102, 0, 32'hFFFFFFFF, 0, 2, 0);
        do_req("lbu_103", 0, 3'b100, 32'h103, 0, 32'h00000080, 0, 2, 0);
        do_req("lb_100", 0, 3'b000, 32'h100, 0, 32'h00000001, 0, 2, 0);
        do_req("lh_100", 0, 3'b001, 32'h100, 0, 32'h00007F01, 0, 2, 0);
        do_req("lh_102", 0, 3'b001, 32'h102, 0, 32'hFFFF80FF, 0, 2, 0);
        do_req("lhu_102", 0, 3'b101, 32'h102, 0, 32'h000080FF, 0, 2, 0);

        do_req("sb_201", 1, 3'b000, 32'h201, 32'hFFFF_FFAA,
               32'h0, 0, 3, 32'h1122AA44);
        do_req("lw_200", 0, 3'b010, 32'h200, 0, 32'h1122AA44, 0, 2, 0);
        do_req("sh_302", 1, 3'b001, 32'h302, 32'h1234BEEF,
               32'h0, 0, 3, 32'hBEEF0000);
        do_req("lh_302", 0, 3'b001, 32'h302, 0, 32'hFFFFBEEF, 0, 2, 0);
        do_req("lhu_302", 0, 3'b101, 32'h302, 0, 32'h0000BEEF, 0, 2, 0);
        do_req("sw_304", 1, 3'b010, 32'h304, 32'hDEADBEEF,
               32'h0, 0, 3, 32'hDEADBEEF);
        do_req("lw_304", 0, 3'b010, 32'h304, 0, 32'hDEADBEEF, 0, 2, 0);

`ifdef LSU_MISALIGN_TRAP_EN
        do_req("lw_105", 0, 3'b010, 32'h105, 0, 32'h0, 1, 2, 0);
        do_req("sh_301", 1, 3'b001, 32'h301, 32'h1111,
               32'h0, 1, 2, 0);
`else
        do_req("lw_105", 0, 3'b010, 32'h105, 0, 32'h55667788, 0, 2, 0);
        do_req("sh_301", 1, 3'b001, 32'h301, 32'h1111,
               32'h0, 0, 3, 32'hBEEF1111);
`endif

        do_req("ill_st_011", 1, 3'b011, 32'h200, 32'h99999999,
               32'h0, 1, 2, 0);
        do_req("ill_ld_110", 0, 3'b110, 32'h100, 0, 32'h0, 1, 2, 0);
        do_req("lw_200_kept", 0, 3'b010, 32'h200, 0,
               32'h1122AA44, 0, 2, 0);

        // Reset asserted in the WRITE cycle of a word store.
        drive(1, 3'b010, 32'h400, 32'h01234567);
        @(negedge clock);
        @(negedge clock);
        check("rstw_we_before", {31'b0, mem_writeEn}, 32'd1);
        reset = 1'b0;
        #1;
        check("rstw_we_async", {31'b0, mem_writeEn}, 32'd0);
        check("rstw_ready_async", {31'b0, req_ready}, 32'd1);
        pulses = 0;
        @(negedge clock);
        if (resp_valid) pulses++;
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (resp_valid) pulses++;
        end
        check("rstw_no_resp", pulses, 0);
        check("rstw_ready", {31'b0, req_ready}, 32'd1);

        do_req("lb_after_rst", 0, 3'b000, 32'h102, 0,
               32'hFFFFFFFF, 0, 2, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multicycle initiator for the word-addressed data memory. It accepts byte, halfword and word load/store requests from the core datapath. It issues word-aligned accesses on the memory port, and performs read-modify-write for sub-word stores. It returns sign- or zero-extended load data with a one-cycle response pulse. It sits between the execute stage and the data memory, and owns every memory address and write-enable the core produces.

## Interface

Parameters:
- `ADDR_W`, 32, byte-address width
- `DATA_W`, 32, data width; fixed at 32, no other value supported

Ports:
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit can accept a request
- `req_write`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RISC-V funct3 size/sign code
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data, right-justified
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_rdata`  out  32  extended load data; 0 for stores and errors
- `resp_error`  out  1  request rejected, valid with `resp_valid`
- `mem_writeEn`  out  1  memory write strobe
- `mem_address`  out  32  word-aligned byte address, low 2 bits always 0
- `mem_write_data`  out  32  merged word to write
- `mem_read_data`  in  32  combinational read of word at `mem_address`

## Operation

- **Load codes:** 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- **Store codes:** 000 SB, 001 SH, 010 SW.
- **Illegal codes:** any other code, for either direction, is illegal and sets `resp_error`. Memory is untouched.
- **FSM states:** IDLE, ACCESS, WRITE, RESP.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`, latch write, funct3, addr and wdata. Go to ACCESS.
- **ACCESS:**
  - `mem_address`={addr[31:2],2'b00}. Sample `mem_read_data`.
  - Load: select the lane by addr[1:0]. Sign-extend for LB/LH, zero-extend for LBU/LHU. Register the result. Go to RESP.
  - Store: merge the low byte/half/word of wdata into the sampled word at lane addr[1:0]. Go to WRITE.
  - Error: go to RESP with error set. No write.
- **WRITE:** `mem_writeEn`=1, `mem_address` held, `mem_write_data`=merged word. Go to RESP.
- **RESP:** `resp_valid`=1 for exactly one cycle. Go to IDLE. There is no response backpressure.
- **Request stability:** request inputs are ignored outside IDLE. The core holds `req_valid` until it sees `req_ready`.
- **Outputs outside RESP:** `resp_rdata` and `resp_error` are 0.
- **Outputs outside ACCESS/WRITE:** `mem_address` and `mem_write_data` are 0.

## Timing

- **Cycle 0:** the cycle in which `req_valid && req_ready` holds.
- **Load:** ACCESS in cycle 1, `resp_valid` in cycle 2. Latency is 2.
- **Store:** ACCESS in cycle 1, WRITE in cycle 2 (memory updates at the end of cycle 2), `resp_valid` in cycle 3. Latency is 3.
- **Error:** `resp_valid` in cycle 2, with no WRITE cycle.
- **Back-to-back requests:** the next request is accepted in the cycle after RESP, at the earliest. Throughput is one load per 3 cycles and one store per 4 cycles.
- **Reset values:** FSM IDLE. `req_ready`=1; all other outputs are 0.
- **Reset mid-operation:** an in-flight request is dropped with no response. If reset asserts during WRITE, the write strobe deasserts asynchronously and no partial write is guaranteed.

## Configuration

- **`LSU_MISALIGN_TRAP_EN` defined:**
  - Halfword with addr[0]=1 sets `resp_error`.
  - Word with addr[1:0]≠0 sets `resp_error`.
  - No memory write occurs.
- **`LSU_MISALIGN_TRAP_EN` undefined:**
  - Misaligned addresses are truncated to natural alignment: halfword uses addr[1] only; word ignores addr[1:0].
  - Misalignment never raises an error. Illegal funct3 still errors.

## Structure

- **Package `lsu_pkg`:** FSM state enum, funct3 constants (LB..LHU, SB..SW), lane-select helper constants.
- **Sub-module `lsu_align`:** combinational.
  - Load path: lane extract plus sign/zero extension from (word, addr[1:0], funct3).
  - Store path: lane merge from (old word, wdata, addr[1:0], funct3).
  - It is shared by the ACCESS load and store paths.

## Test plan

- **LB:** memory word at 0x100 = 0x80FF7F01; LB at 0x102 → `resp_rdata`=0xFFFFFFFF, `resp_valid` in cycle 2. LBU at 0x103 → 0x00000080.
- **SB:** word at 0x200 = 0x11223344; SB 0xAA at 0x201 → `mem_writeEn` in cycle 2 with data 0x1122AA44, `resp_valid` in cycle 3. A following LW at 0x200 reads 0x1122AA44.
- **SH/LH:** SH 0xBEEF at 0x302, then LH at 0x302 → 0xFFFFBEEF. LHU at 0x302 → 0x0000BEEF.
- **Misaligned LW at 0x105:**
  - With `LSU_MISALIGN_TRAP_EN`: `resp_error`=1, `resp_rdata`=0.
  - Without it: returns the word at 0x104 with no error.
- **Illegal funct3:** funct3=011 store → `resp_error`=1, `mem_writeEn` never asserts.
- **Reset during WRITE:** assert `reset` low in cycle 2 of an SW → no `resp_valid`, `mem_writeEn`=0 immediately, `req_ready`=1 after release.
